// File: rtl/crc_scan_pkg.sv
// Shared state encoding, CRC-32 constants and the reflected byte-update helper
// for the CRC memory scanner.
package crc_scan_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned CRC_W      = 32;

  localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF    = 32'hFFFFFFFF;
  localparam logic [CRC_W-1:0] CRC_XOROUT_DEF  = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } scan_state_t;

  // One byte through the reflected CRC-32, bit 0 of the byte first.
  function automatic logic [CRC_W-1:0] crc32_byte_refl(input logic [CRC_W-1:0] crc,
                                                       input logic [7:0]       data);
    logic [CRC_W-1:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d32_refl.sv
// Combinational 32-bit-per-cycle reflected CRC-32 update: four chained byte
// updates, readdata[7:0] first and [31:24] last.
module crc32_d32_refl
  import crc_scan_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic [31:0]      data,
  output logic [CRC_W-1:0] crc_next_c
);

  logic [CRC_W-1:0] crc_b0;
  logic [CRC_W-1:0] crc_b1;
  logic [CRC_W-1:0] crc_b2;

  assign crc_b0     = crc32_byte_refl(crc_in, data[7:0]);
  assign crc_b1     = crc32_byte_refl(crc_b0, data[15:8]);
  assign crc_b2     = crc32_byte_refl(crc_b1, data[23:16]);
  assign crc_next_c = crc32_byte_refl(crc_b2, data[31:24]);

endmodule

// File: rtl/crc_mem_scanner.sv
// Avalon-MM read master that streams a block of on-chip RAM words through a
// CRC-32 engine. Define CRC_SCAN_WRITEBACK_EN to write the result back to base+len.
module crc_mem_scanner
  import crc_scan_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [CRC_W-1:0]  CRC_INIT   = CRC_INIT_DEF,
  parameter logic [CRC_W-1:0]  CRC_XOROUT = CRC_XOROUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len_words,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [CRC_W-1:0]  crc_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  scan_state_t       state, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued, issued_d;
  logic              rd_valid;
  logic [CRC_W-1:0]  crc_reg;
  logic [CRC_W-1:0]  crc_next_c;

  logic              done_d;
  logic              len_err_d;
  logic [CRC_W-1:0]  crc_out_d;
  logic [ADDR_W-1:0] mem_address_d;
  logic              mem_chipselect_d;

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  crc32_d32_refl u_crc (
    .crc_in     (crc_reg),
    .data       (mem_readdata),
    .crc_next_c (crc_next_c)
  );

`ifdef CRC_SCAN_WRITEBACK_EN
  logic        mem_write_d;
  logic [31:0] mem_writedata_d;
`else
  assign mem_write     = 1'b0;
  assign mem_writedata = 32'h0;
`endif

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_d          = state;
    base_d           = base_q;
    len_d            = len_q;
    issued_d         = issued;
    done_d           = 1'b0;
    len_err_d        = 1'b0;
    crc_out_d        = crc_out;
    mem_address_d    = mem_address;
    mem_chipselect_d = 1'b0;
`ifdef CRC_SCAN_WRITEBACK_EN
    mem_write_d      = 1'b0;
    mem_writedata_d  = mem_writedata;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (len_words == '0) begin
            done_d    = 1'b1;
            crc_out_d = CRC_INIT ^ CRC_XOROUT;
          end else if (len_words > DEPTH) begin
            done_d    = 1'b1;
            len_err_d = 1'b1;
          end else begin
            state_d          = READ;
            base_d           = base_addr;
            len_d            = len_words;
            issued_d         = LEN_ONE;
            mem_chipselect_d = 1'b1;
            mem_address_d    = base_addr;
          end
        end
      end
      READ: begin
        if (issued == len_q) begin
          state_d = DRAIN;
        end else begin
          mem_chipselect_d = 1'b1;
          mem_address_d    = base_q + issued[ADDR_W-1:0];
          issued_d         = issued + LEN_ONE;
        end
      end
      DRAIN: begin
`ifdef CRC_SCAN_WRITEBACK_EN
        state_d = WB;
`else
        state_d = DONE;
`endif
      end
      WB: begin
`ifdef CRC_SCAN_WRITEBACK_EN
        // Final CRC is complete here; the write beat is presented during DONE.
        state_d          = DONE;
        mem_chipselect_d = 1'b1;
        mem_write_d      = 1'b1;
        mem_address_d    = base_q + len_q[ADDR_W-1:0];
        mem_writedata_d  = crc_reg ^ CRC_XOROUT;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        crc_out_d = crc_reg ^ CRC_XOROUT;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      issued         <= '0;
      rd_valid       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      len_err        <= 1'b0;
      crc_out        <= '0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
`ifdef CRC_SCAN_WRITEBACK_EN
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
`endif
    end else begin
      state          <= state_d;
      base_q         <= base_d;
      len_q          <= len_d;
      issued         <= issued_d;
      rd_valid       <= mem_chipselect & ~mem_write;
      busy           <= (state_d != IDLE);
      done           <= done_d;
      len_err        <= len_err_d;
      crc_out        <= crc_out_d;
      mem_address    <= mem_address_d;
      mem_chipselect <= mem_chipselect_d;
`ifdef CRC_SCAN_WRITEBACK_EN
      mem_write      <= mem_write_d;
      mem_writedata  <= mem_writedata_d;
`endif
    end
  end

  // Running CRC: reseeded whenever idle, advanced on each returning read beat.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      crc_reg <= CRC_INIT;
    end else if (state == IDLE) begin
      crc_reg <= CRC_INIT;
    end else if (rd_valid) begin
      crc_reg <= crc_next_c;
    end
  end

endmodule

// File: tb/tb_crc_mem_scanner.sv
// Directed self-checking bench for crc_mem_scanner with a 1-cycle-latency RAM
// model; expectations follow CRC_SCAN_WRITEBACK_EN when it is defined.
module tb_crc_mem_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] len_words;
  logic        busy, done, len_err;
  logic [31:0] crc_out;
  logic [9:0]  mem_address;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  logic [31:0] ram [0:1023];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;

  int vectors     = 0;
  int miscompares = 0;

  int          lat, cs_cnt, first_cs, last_cs, busy_bad, wr_cnt, wr_cyc, done_cnt;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        lerr_at_done;
  logic [9:0]  addr_log [16];
  logic [31:0] mw [4];

  always #5 clk = ~clk;

  crc_mem_scanner dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .len_words      (len_words),
    .busy           (busy),
    .done           (done),
    .len_err        (len_err),
    .crc_out        (crc_out),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  // Single-port RAM, registered read, plus a bench-side load port.
  always @(posedge clk) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (mem_clken && mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
    if (mem_clken && mem_chipselect) mem_readdata <= ram[mem_address];
  end

  function automatic logic [31:0] crc_model(input logic [31:0] w [4], input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 32; b++) begin
        if (c[0] ^ w[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue one command and watch the bus until done (bounded); a second start
  // is pulsed during cycle 'inject' when inject > 0.
  task automatic run_scan(input logic [9:0] b, input logic [10:0] l, input int inject);
    int cyc;
    lat = -1; cs_cnt = 0; first_cs = -1; last_cs = -1; busy_bad = 0; wr_cyc = -1;
    wr_addr = '0; wr_data = '0; lerr_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = b; len_words = l;
    cyc = 0;
    while (lat < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject);
      if (start) begin base_addr = 10'd500; len_words = 11'd1; end
      if (mem_chipselect && !mem_write) begin
        if (cs_cnt < 16) addr_log[cs_cnt] = mem_address;
        if (first_cs < 0) first_cs = cyc;
        last_cs = cyc;
        cs_cnt++;
      end
      if (mem_write) begin
        wr_cnt++; wr_cyc = cyc; wr_addr = mem_address; wr_data = mem_writedata;
      end
      if (done ? busy : !busy) busy_bad++;
      if (done) begin lat = cyc; lerr_at_done = len_err; end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat_extra;
`ifdef CRC_SCAN_WRITEBACK_EN
    lat_extra = 1;
`else
    lat_extra = 0;
`endif
    wr_cnt = 0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; len_words = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_cs", 32'(mem_chipselect), 32'h0);
    chk("rst_crc", crc_out, 32'h0);
    chk("rst_be_clken", {27'h0, mem_byteenable, mem_clken}, 32'h1F);
    reset_n = 1'b1;

    // "1234" in one word
    poke(10'd0, 32'h34333231);
    run_scan(10'd0, 11'd1, 0);
    chk("w1234_lat", 32'(lat), 32'(4 + lat_extra));
    chk("w1234_crc", crc_out, 32'h9BE3E0A3);
    chk("w1234_lerr", 32'(lerr_at_done), 32'h0);
    chk("w1234_cs", 32'(cs_cnt), 32'h1);
    chk("w1234_busy", 32'(busy_bad), 32'h0);
`ifdef CRC_SCAN_WRITEBACK_EN
    chk("wb_addr", 32'(wr_addr), 32'h1);
    chk("wb_data", wr_data, 32'h9BE3E0A3);
    chk("wb_cyc", 32'(wr_cyc), 32'(lat - 1));
`endif

    // oversize length: error, crc unchanged, no bus traffic
    run_scan(10'd3, 11'd1025, 0);
    chk("len1025_lat", 32'(lat), 32'h1);
    chk("len1025_lerr", 32'(lerr_at_done), 32'h1);
    chk("len1025_crc", crc_out, 32'h9BE3E0A3);
    chk("len1025_cs", 32'(cs_cnt), 32'h0);

    // zero length
    run_scan(10'd3, 11'd0, 0);
    chk("len0_lat", 32'(lat), 32'h1);
    chk("len0_crc", crc_out, 32'h0);
    chk("len0_lerr", 32'(lerr_at_done), 32'h0);
    chk("len0_cs", 32'(cs_cnt), 32'h0);

    poke(10'd5, 32'h00000000);
    run_scan(10'd5, 11'd1, 0);
    chk("zero_word_crc", crc_out, 32'h2144DF1C);
    poke(10'd5, 32'hFFFFFFFF);
    run_scan(10'd5, 11'd1, 0);
    chk("ones_word_crc", crc_out, 32'hFFFFFFFF);

    // "12345678" across two words
    poke(10'd10, 32'h34333231);
    poke(10'd11, 32'h38373635);
    run_scan(10'd10, 11'd2, 0);
    chk("w2_lat", 32'(lat), 32'(5 + lat_extra));
    chk("w2_crc", crc_out, 32'h9AE0DAAF);

    // address wrap 1022,1023,0,1
    mw[0] = 32'hDEADBEEF; mw[1] = 32'h01234567; mw[2] = 32'h89ABCDEF; mw[3] = 32'h5A5AA5A5;
    poke(10'd1022, mw[0]);
    poke(10'd1023, mw[1]);
    poke(10'd0, mw[2]);
    poke(10'd1, mw[3]);
    run_scan(10'd1022, 11'd4, 0);
    chk("wrap_a0", 32'(addr_log[0]), 32'd1022);
    chk("wrap_a1", 32'(addr_log[1]), 32'd1023);
    chk("wrap_a2", 32'(addr_log[2]), 32'd0);
    chk("wrap_a3", 32'(addr_log[3]), 32'd1);
    chk("wrap_cs_cnt", 32'(cs_cnt), 32'd4);
    chk("wrap_cs_span", 32'(last_cs - first_cs + 1), 32'd4);
    chk("wrap_cs_first", 32'(first_cs), 32'd1);
    chk("wrap_crc", crc_out, crc_model(mw, 4));
    chk("wrap_lat", 32'(lat), 32'(7 + lat_extra));

    // reset during READ of a 16-word scan
    @(negedge clk);
    start = 1'b1; base_addr = 10'd0; len_words = 11'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_cs", 32'(mem_chipselect), 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_cs", 32'(mem_chipselect), 32'h0);
    chk("abort_addr", 32'(mem_address), 32'h0);
    chk("abort_crc", crc_out, 32'h0);
    chk("abort_lerr", 32'(len_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'h0);

    // restart with a start pulse while busy
    mw[0] = 32'h11111111; mw[1] = 32'h22222222; mw[2] = 32'h33333333; mw[3] = 32'h0;
    poke(10'd0, mw[0]);
    poke(10'd1, mw[1]);
    poke(10'd2, mw[2]);
    run_scan(10'd0, 11'd3, 2);
    chk("restart_lat", 32'(lat), 32'(6 + lat_extra));
    chk("restart_cs", 32'(cs_cnt), 32'd3);
    chk("restart_crc", crc_out, crc_model(mw, 3));
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("restart_one_done", 32'(done_cnt), 32'h0);
    chk("restart_idle", 32'(busy), 32'h0);

`ifndef CRC_SCAN_WRITEBACK_EN
    chk("no_writes", 32'(wr_cnt), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
